acos_search: RTL and testbench
==============================

Name: acos_search

Overview:
- Inverse of the cosine lookup. Given a 16-bit target value, it finds the largest angle address whose cosine ROM entry is greater than or equal to the target.
- Method is a successive-approximation binary search over an external synchronous cosine ROM, which this block drives through an address/data port pair.
- Sits beside the cosine ROM in the calc datapath. Converts a measured component back to an angle index.

Parameters:
- ADDR_W, 12, angle/ROM address width; result width.
- DATA_W, 16, ROM data and target width; signed two's complement.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- target  input  DATA_W  signed search value; captured when start is accepted.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when angle/miss are valid.
- angle  output  ADDR_W  result; holds until the next done.
- miss  output  1  target exceeds rom(0); only meaningful with the optional feature.
- rom_addr  output  ADDR_W  registered address to the ROM.
- rom_data  input  DATA_W  ROM read data, valid one cycle after rom_addr is presented.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n; the polarity and synchronicity are fixed. On assertion: state=IDLE, busy=0, done=0, angle=0, miss=0, rom_addr=0, internal result and target registers = 0.
- ROM contract: rom_addr is presented in cycle k; the ROM registers it at the end of k; rom_data is valid in cycle k+1. The ROM contents are monotonically non-increasing in address (cos over 0..pi).
- States: IDLE, PROBE, CMP, FIN.
- IDLE (cycle T, start=1):
  - capture target; r=0; bit index b=ADDR_W-1.
  - rom_addr <= 1<<b; busy <= 1; go to PROBE.
- PROBE: no action; the ROM samples rom_addr. Go to CMP.
- CMP: rom_data corresponds to cand = r | (1<<b).
  - If signed(rom_data) >= signed(target_q), then r = cand.
  - If b>0: b=b-1; rom_addr <= r_new | (1<<(b-1)) in the new bit position; go to PROBE.
  - If b==0: go to FIN.
- FIN:
  - angle <= r; done <= 1 for exactly one cycle.
  - busy <= 0 in the same edge; return to IDLE.
  - rom_addr holds its last value.
- Latency: start accepted at edge T. CMP for the last bit occurs in cycle T+2*ADDR_W. done and busy=0 are visible in cycle T+2*ADDR_W+1 (T+25 for ADDR_W=12). Throughput is one search per 2*ADDR_W+1 cycles.
- start while busy is ignored. target changes after acceptance are ignored.
- Back-to-back: a start asserted in the cycle done is visible is accepted, because the state is IDLE.
- Boundaries:
  - target <= rom(max): angle = 2^ADDR_W-1.
  - target > rom(1<<(ADDR_W-1)) and all probes fail: angle=0.
  - Without the feature, target > rom(0) also yields angle=0 and is indistinguishable from that case.
- Reset mid-search: immediate return to IDLE with all outputs at their reset values. No done pulse is produced.
- Comparison is full DATA_W signed; no rounding or saturation.

Optional Feature:
- Macro: ACOS_RANGE_CHECK_EN.
- Defined:
  - An extra PROBE/CMP pair at address 0 precedes the bit search.
  - If signed(rom(0)) < target: miss=1, angle=0, skip straight to FIN.
  - Otherwise miss=0 and the search proceeds.
  - Latency becomes 2*ADDR_W+3 cycles (T+27) when there is no miss, and 3 cycles (T+3) on a miss.
  - miss is updated together with done.
- Undefined: the miss output is tied to 0 and the latency is as in Behaviour.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults and the state encoding constants (IDLE, PROBE, CMP, FIN). The cosine ROM uses the same width constants from this package.
- No sub-module is natural: it is a single SAR FSM. The ROM stays external so that it can be shared with the forward cosine path.

Test Plan:
- Bench uses a behavioural ROM with a 1-cycle registered read, rom(a)=2047-a as a signed 16-bit value.
- target=1047, start at T -> done pulse at T+25, angle=1000, busy high T+1..T+24, rom_addr sequence starts 2048, 1024, ...
- target=-2048 -> angle=4095. target=-3000 -> angle=4095.
- target=3000 -> angle=0. With ACOS_RANGE_CHECK_EN: miss=1, done at T+3.
- start re-pulsed at T+5 during a search -> ignored; one done at T+25. New start in the done cycle -> second done at T+50.
- rst_n low at T+10 -> busy=0, rom_addr=0, angle=0 immediately (asynchronous); no done. A search after release completes normally.

Source files
------------

// File: rtl/acos_search_pkg.sv
// acos_search_pkg
//   Shared widths and FSM state encoding for the inverse-cosine search.
//   The external cosine ROM uses the same width constants.
//   Contents:
//     ACOS_ADDR_W  angle / ROM address width (default 12)
//     ACOS_DATA_W  ROM data / target width, signed (default 16)
//     state_e      search FSM states
package acos_search_pkg;

  localparam int ACOS_ADDR_W = 12;
  localparam int ACOS_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_CMP   = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/acos_search_if.sv
// acos_search_if
//   Bundles the request/result handshake and the ROM address/data pair
//   of the inverse-cosine search.
//   Signals:
//     start     request pulse (requester -> search)
//     target    signed search value (requester -> search)
//     busy      search in progress (search -> requester)
//     done      one-cycle result strobe (search -> requester)
//     angle     result angle index (search -> requester)
//     miss      target above rom(0), range-check build only (search -> requester)
//     rom_addr  registered ROM address (search -> ROM)
//     rom_data  ROM read data, one cycle after rom_addr (ROM -> search)
//   Modports: slave = the search block, master = requester plus ROM side.
interface acos_search_if
  import acos_search_pkg::*;
#(
  parameter int ADDR_W = ACOS_ADDR_W,
  parameter int DATA_W = ACOS_DATA_W
) ();

  logic              start;
  logic [DATA_W-1:0] target;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] angle;
  logic              miss;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  start, target, rom_data,
    output busy, done, angle, miss, rom_addr
  );

  modport master (
    output start, target, rom_data,
    input  busy, done, angle, miss, rom_addr
  );

endinterface

// File: rtl/acos_search.sv
// acos_search
//   Inverse of the cosine lookup: finds the largest angle address whose
//   cosine ROM entry is >= a signed target, by successive approximation
//   over an external synchronous ROM (one PROBE/CMP pair per result bit).
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    acos_search_if.slave: start/target in, busy/done/angle/miss
//            out, rom_addr out, rom_data in
//   Optional feature (macro ACOS_RANGE_CHECK_EN): an extra probe of
//   address 0 before the bit search; a target above rom(0) ends the
//   search early with miss=1, angle=0. Without the macro miss is tied 0.
//   ADDR_W/DATA_W must match the parameters of the connected interface.
module acos_search
  import acos_search_pkg::*;
#(
  parameter int ADDR_W = ACOS_ADDR_W,
  parameter int DATA_W = ACOS_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  acos_search_if.slave bus
);

  localparam int BIT_W = $clog2(ADDR_W);
  localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE = {{(BIT_W-1){1'b0}}, 1'b1};

  // One-hot address mask for result bit idx
  function automatic logic [ADDR_W-1:0] bit_mask(input logic [BIT_W-1:0] idx);
    logic [ADDR_W-1:0] m;
    m = {{(ADDR_W-1){1'b0}}, 1'b1} << idx;
    return m;
  endfunction

  state_e                   state_r,  state_s;
  logic signed [DATA_W-1:0] target_r, target_s;
  logic [ADDR_W-1:0]        res_r,    res_s;
  logic [BIT_W-1:0]         bit_r,    bit_s;
  logic [ADDR_W-1:0]        addr_r,   addr_s;
  logic                     busy_r,   busy_s;
  logic                     done_r,   done_s;
  logic [ADDR_W-1:0]        angle_r,  angle_s;
  logic                     ge_s;
  logic [ADDR_W-1:0]        step_res_s;
`ifdef ACOS_RANGE_CHECK_EN
  logic                     miss_r,   miss_s;
  logic                     rc_r,     rc_s;   // current CMP is the address-0 range probe
`endif

  // Candidate acceptance: ROM entry for res|bit meets the target
  always_comb begin
    ge_s       = $signed(bus.rom_data) >= target_r;
    step_res_s = ge_s ? (res_r | bit_mask(bit_r)) : res_r;
  end

  // Next-state and next-register logic of the SAR search
  always_comb begin
    state_s  = state_r;
    target_s = target_r;
    res_s    = res_r;
    bit_s    = bit_r;
    addr_s   = addr_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    angle_s  = angle_r;
`ifdef ACOS_RANGE_CHECK_EN
    miss_s   = miss_r;
    rc_s     = rc_r;
`endif
    case (state_r)
      // FIN is the done cycle; it accepts a new start exactly like IDLE
      ST_IDLE, ST_FIN: begin
        if (bus.start) begin
          target_s = bus.target;
          res_s    = {ADDR_W{1'b0}};
          bit_s    = TOP_BIT;
          busy_s   = 1'b1;
          state_s  = ST_PROBE;
`ifdef ACOS_RANGE_CHECK_EN
          addr_s   = {ADDR_W{1'b0}};
          rc_s     = 1'b1;
`else
          addr_s   = bit_mask(TOP_BIT);
`endif
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_PROBE: begin
        state_s = ST_CMP;
      end
      ST_CMP: begin
`ifdef ACOS_RANGE_CHECK_EN
        if (rc_r) begin
          rc_s = 1'b0;
          if (!ge_s) begin
            miss_s  = 1'b1;
            angle_s = {ADDR_W{1'b0}};
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_FIN;
          end else begin
            addr_s  = bit_mask(TOP_BIT);
            state_s = ST_PROBE;
          end
        end else begin
`endif
          res_s = step_res_s;
          if (bit_r != {BIT_W{1'b0}}) begin
            bit_s   = bit_r - BIT_ONE;
            addr_s  = step_res_s | bit_mask(bit_r - BIT_ONE);
            state_s = ST_PROBE;
          end else begin
            // Last bit: publish result on this edge so done shows next cycle
            angle_s = step_res_s;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_FIN;
`ifdef ACOS_RANGE_CHECK_EN
            miss_s  = 1'b0;
`endif
          end
`ifdef ACOS_RANGE_CHECK_EN
        end
`endif
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      target_r <= {DATA_W{1'b0}};
      res_r    <= {ADDR_W{1'b0}};
      bit_r    <= {BIT_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      angle_r  <= {ADDR_W{1'b0}};
`ifdef ACOS_RANGE_CHECK_EN
      miss_r   <= 1'b0;
      rc_r     <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      target_r <= target_s;
      res_r    <= res_s;
      bit_r    <= bit_s;
      addr_r   <= addr_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      angle_r  <= angle_s;
`ifdef ACOS_RANGE_CHECK_EN
      miss_r   <= miss_s;
      rc_r     <= rc_s;
`endif
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.angle    = angle_r;
  assign bus.rom_addr = addr_r;
`ifdef ACOS_RANGE_CHECK_EN
  assign bus.miss     = miss_r;
`else
  assign bus.miss     = 1'b0;
`endif

endmodule

// File: tb/tb_acos_search.sv
// tb_acos_search
//   Self-checking bench for acos_search with a behavioural 1-cycle ROM,
//   rom(a) = 2047 - a. A reference model derives angle/miss/latency from
//   a linear scan of the ROM function; one compare process checks
//   busy/done/angle/miss every cycle. Directed cases pin literal results,
//   then randomized traffic runs against the model.
module tb_acos_search;
  import acos_search_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
`ifdef ACOS_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  int   n_done = 0;

  acos_search_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  acos_search #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous ROM
  always @(posedge clk) begin
    bus.rom_data <= 16'(32'sd2047 - int'(bus.rom_addr));
  end

  function automatic int rom_val(input int a);
    return 2047 - a;
  endfunction

  function automatic int ref_angle(input int t);
    for (int a = (1 << AW) - 1; a >= 0; a--) begin
      if (rom_val(a) >= t) return a;
    end
    return 0;
  endfunction

  function automatic bit ref_miss(input int t);
    return RC && (rom_val(0) < t);
  endfunction

  function automatic int ref_lat(input int t);
    if (RC && rom_val(0) < t) return 3;
    return 2 * AW + 1 + (RC ? 2 : 0);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accept when free, count down to the done cycle
  bit            m_active = 1'b0;
  int            m_left = 0;
  bit            m_done = 1'b0;
  int            m_angle = 0;
  bit            m_miss = 1'b0;
  int            p_angle = 0;
  bit            p_miss = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_left   <= 0;
      m_done   <= 1'b0;
      m_angle  <= 0;
      m_miss   <= 1'b0;
      p_angle  <= 0;
      p_miss   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_angle  <= p_angle;
          m_miss   <= p_miss;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (bus.start) begin
        m_active <= 1'b1;
        m_left   <= ref_lat(int'($signed(bus.target))) - 1;
        p_angle  <= ref_angle(int'($signed(bus.target)));
        p_miss   <= ref_miss(int'($signed(bus.target)));
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  longint'(bus.busy),  longint'(m_active));
      chk("done",  longint'(bus.done),  longint'(m_done));
      chk("angle", longint'(bus.angle), longint'(m_angle));
      chk("miss",  longint'(bus.miss),  longint'(m_miss));
      if (bus.done) n_done++;
    end
  end

  // Directed search: start in the current cycle, wait for done (bounded)
  task automatic run_search(input logic [15:0] t, input int exp_ang, input int exp_lat,
                            input bit exp_miss, input bit chk_addr, input bit repulse);
    int k;
    bit got;
    bus.target = t;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.target = 16'($urandom);
    k   = 1;
    got = 1'b0;
    while (!got && k <= 80) begin
      if (chk_addr) begin
        if (RC) begin
          if (k == 1) chk("rom_addr_k1", longint'(bus.rom_addr), 0);
          if (k == 3) chk("rom_addr_k3", longint'(bus.rom_addr), 2048);
          if (k == 5) chk("rom_addr_k5", longint'(bus.rom_addr), 1024);
        end else begin
          if (k == 1) chk("rom_addr_k1", longint'(bus.rom_addr), 2048);
          if (k == 3) chk("rom_addr_k3", longint'(bus.rom_addr), 1024);
        end
      end
      if (repulse && k == 5) begin
        bus.start  = 1'b1;
        bus.target = 16'h8000;
      end
      if (repulse && k == 6) bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    bus.start = 1'b0;
    chk("done_seen", longint'(got), 1);
    chk("latency", longint'(k), longint'(exp_lat));
    chk("angle_lit", longint'(bus.angle), longint'(exp_ang));
    chk("miss_lit", longint'(bus.miss), longint'(exp_miss));
  endtask

  int lat_full;
  int lat_far;
  bit miss_far;
  logic [15:0] edge_vals [6];

  initial begin
    lat_full = RC ? 27 : 25;
    lat_far  = RC ? 3 : 25;
    miss_far = RC;
    edge_vals[0] = 16'd2047;  edge_vals[1] = 16'd2048;
    edge_vals[2] = 16'hF800;  edge_vals[3] = 16'hF7FF;
    edge_vals[4] = 16'h7FFF;  edge_vals[5] = 16'h8000;

    bus.start  = 1'b0;
    bus.target = 16'd0;

    // Literal pins on the reference model
    chk("model_1047",  longint'(ref_angle(1047)),  1000);
    chk("model_m2048", longint'(ref_angle(-2048)), 4095);
    chk("model_3000",  longint'(ref_angle(3000)),  0);
    chk("model_2047",  longint'(ref_angle(2047)),  0);

    #2 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("rst_busy",     longint'(bus.busy),     0);
    chk("rst_done",     longint'(bus.done),     0);
    chk("rst_angle",    longint'(bus.angle),    0);
    chk("rst_miss",     longint'(bus.miss),     0);
    chk("rst_rom_addr", longint'(bus.rom_addr), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_search(16'd1047, 1000, lat_full, 1'b0, 1'b1, 1'b0);
    // Back-to-back: the next start lands in the done cycle
    run_search(16'hF800, 4095, lat_full, 1'b0, 1'b0, 1'b0);
    run_search(16'hF448, 4095, lat_full, 1'b0, 1'b0, 1'b0);  // -3000
    run_search(16'd3000, 0,    lat_far,  miss_far, 1'b0, 1'b0);
    run_search(16'd2047, 0,    lat_full, 1'b0, 1'b0, 1'b0);
    run_search(16'd0,    2047, lat_full, 1'b0, 1'b0, 1'b0);
    run_search(16'd1047, 1000, lat_full, 1'b0, 1'b0, 1'b1);  // start re-pulsed mid-search
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a search
    bus.target = 16'd1047;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy",     longint'(bus.busy),     0);
    chk("midrst_done",     longint'(bus.done),     0);
    chk("midrst_rom_addr", longint'(bus.rom_addr), 0);
    chk("midrst_angle",    longint'(bus.angle),    0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run_search(16'd1047, 1000, lat_full, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       bus.target = 16'($urandom);
        1:       bus.target = 16'($urandom_range(0, 8191)) - 16'd4096;
        2:       bus.target = edge_vals[$urandom_range(0, 5)];
        default: bus.target = 16'($urandom_range(0, 4095)) - 16'd2048;
      endcase
      @(negedge clk);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 60 && m_active; i++) @(negedge clk);
    chk("drain_idle", longint'(m_active), 0);
    chk("random_dones_seen", longint'(n_done > 100), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
